// File: rtl/frame_commit_pkg.sv
// rtl/frame_commit_pkg.sv - shared state encoding and game-object word map for the frame commit controller
package frame_commit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COPY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_BALL      = 3'd0;
    localparam logic [IDX_W-1:0] IDX_LPADDLE   = 3'd1;
    localparam logic [IDX_W-1:0] IDX_RPADDLE   = 3'd2;
    localparam logic [IDX_W-1:0] IDX_NOTES1    = 3'd3;
    localparam logic [IDX_W-1:0] IDX_NOTES2    = 3'd4;
    localparam logic [IDX_W-1:0] IDX_NOTES3    = 3'd5;
    localparam logic [IDX_W-1:0] IDX_NOTES4    = 3'd6;
    localparam logic [IDX_W-1:0] IDX_GAME_INFO = 3'd7;

endpackage

// File: rtl/vsync_edge_sync.sv
// rtl/vsync_edge_sync.sv - synchroniser for the asynchronous VGA vsync plus registered falling-edge flag
module vsync_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic vsync_async,
    output logic edge_flag
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;

    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(vsync_async);
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = prev_q & ~sync_q[SYNC_STAGES-1];
    end

    // vsync idles high, so the chain resets high to avoid a false edge on release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign edge_flag = edge_q;

endmodule

// File: rtl/frame_commit_ctrl.sv
// rtl/frame_commit_ctrl.sv - double-buffer commit of game-object words into the display set on vsync
// FRAME_COMMIT_DIRTY_EN: copy only words written since their last copy.
module frame_commit_ctrl
    import frame_commit_pkg::*;
#(
    parameter int NUM_WORDS   = 8,
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync_async,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              commit_req,
    output logic              busy,
    output logic              frame_tick,
    output logic              disp_we,
    output logic [2:0]        disp_idx,
    output logic [WORD_W-1:0] disp_data,
    output logic [15:0]       frame_count,
    output logic [7:0]        dropped_frames,
    output logic [7:0]        wr_drop_cnt,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic vs_edge;

    vsync_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clock       (clock),
        .reset       (reset),
        .vsync_async (vsync_async),
        .edge_flag   (vs_edge)
    );

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [WORD_W-1:0] working_q [NUM_WORDS];
    logic [WORD_W-1:0] working_d [NUM_WORDS];
    logic              disp_we_q, disp_we_d;
    logic [IDX_W-1:0]  disp_idx_q, disp_idx_d;
    logic [WORD_W-1:0] disp_data_q, disp_data_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [7:0]        dropped_q, dropped_d;
    logic [7:0]        wr_drop_q, wr_drop_d;
    logic              overrun_q, overrun_d;
`ifdef FRAME_COMMIT_DIRTY_EN
    logic [NUM_WORDS-1:0] dirty_q, dirty_d;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        working_d     = working_q;
        disp_we_d     = 1'b0;
        disp_idx_d    = disp_idx_q;
        disp_data_d   = disp_data_q;
        frame_count_d = frame_count_q;
        dropped_d     = dropped_q;
        wr_drop_d     = wr_drop_q;
        overrun_d     = overrun_q;
`ifdef FRAME_COMMIT_DIRTY_EN
        dirty_d       = dirty_q;
`endif

        case (state_q)
            IDLE:  if (commit_req) state_d = ARMED;
            ARMED: if (vs_edge) begin
                state_d = COPY;
                ptr_d   = '0;
            end
            COPY:  if (ptr_q == LAST_IDX) state_d = DONE;
                   else ptr_d = ptr_q + 1'b1;
            DONE:  state_d = commit_req ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            if (state_q == COPY) begin
                if (wr_drop_q != 8'hFF) wr_drop_d = wr_drop_q + 8'd1;
            end else if (int'(wr_idx) < NUM_WORDS) begin
                working_d[wr_idx] = wr_data;
`ifdef FRAME_COMMIT_DIRTY_EN
                dirty_d[wr_idx] = 1'b1;
`endif
            end
        end

`ifdef FRAME_COMMIT_DIRTY_EN
        if (state_q == COPY) dirty_d[ptr_q] = 1'b0;
`endif

        if (vs_edge) begin
            frame_count_d = frame_count_q + 16'd1;
            if (state_q == IDLE && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
            if (state_q == COPY) overrun_d = 1'b1;
        end

        // display strobe is registered so it lines up with the cycles spent in COPY
        if (state_d == COPY) begin
`ifdef FRAME_COMMIT_DIRTY_EN
            disp_we_d = dirty_d[ptr_d];
`else
            disp_we_d = 1'b1;
`endif
            if (disp_we_d) begin
                disp_idx_d  = ptr_d;
                disp_data_d = working_d[ptr_d];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            for (int i = 0; i < NUM_WORDS; i++) working_q[i] <= '0;
            disp_we_q     <= 1'b0;
            disp_idx_q    <= '0;
            disp_data_q   <= '0;
            frame_count_q <= '0;
            dropped_q     <= '0;
            wr_drop_q     <= '0;
            overrun_q     <= 1'b0;
`ifdef FRAME_COMMIT_DIRTY_EN
            dirty_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            working_q     <= working_d;
            disp_we_q     <= disp_we_d;
            disp_idx_q    <= disp_idx_d;
            disp_data_q   <= disp_data_d;
            frame_count_q <= frame_count_d;
            dropped_q     <= dropped_d;
            wr_drop_q     <= wr_drop_d;
            overrun_q     <= overrun_d;
`ifdef FRAME_COMMIT_DIRTY_EN
            dirty_q       <= dirty_d;
`endif
        end
    end

    assign busy           = (state_q == ARMED) || (state_q == COPY);
    assign frame_tick     = vs_edge;
    assign disp_we        = disp_we_q;
    assign disp_idx       = disp_idx_q;
    assign disp_data      = disp_data_q;
    assign frame_count    = frame_count_q;
    assign dropped_frames = dropped_q;
    assign wr_drop_cnt    = wr_drop_q;
    assign overrun        = overrun_q;

endmodule

// File: doc/frame_commit_ctrl.md
Name: frame_commit_ctrl

Overview:
Double-buffer controller between the processor's game-object writes and the VGA display registers (ball, paddles, note rows, game_info).
- Processor writes a working set at any time, then raises commit_req.
- On the next VGA vertical-sync falling edge, the block copies the working set word-by-word to the display set, so each frame renders one consistent game state.
- Also supplies a per-frame tick and frame/drop counters for game timing.

Parameters:
NUM_WORDS, 8, number of 32-bit game-object words in working/display sets
WORD_W, 32, data width per word
SYNC_STAGES, 2, flip-flop stages synchronising VGA_VS into the clock domain

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
vsync_async  in  1  VGA_VS from the VGA controller, active-low, asynchronous
wr_en  in  1  processor write strobe into working set
wr_idx  in  3  working-set word index
wr_data  in  WORD_W  write data
commit_req  in  1  level or pulse; working set ready for display
busy  out  1  high in ARMED or COPY
frame_tick  out  1  one-cycle pulse per detected vsync edge
disp_we  out  1  display-set write strobe
disp_idx  out  3  display-set word index
disp_data  out  WORD_W  display-set write data
frame_count  out  16  vsync edges since reset, wraps
dropped_frames  out  8  vsync edges with no commit pending, saturating at 255
wr_drop_cnt  out  8  writes discarded during COPY, saturating
overrun  out  1  sticky: vsync edge seen during COPY

Behaviour:
- Reset (async): state IDLE; working array cleared to 0; all outputs and counters 0; overrun cleared.
  - Reset during COPY aborts immediately. The display set stays partially updated; this is accepted.
- Vsync detect: vsync_async passes through SYNC_STAGES flops. A falling edge is flagged SYNC_STAGES+1 cycles after the input transition.
- Each edge: frame_tick=1 for one cycle; frame_count+1.
- States:
  - IDLE: commit_req=1 -> ARMED next cycle. Vsync edge in IDLE -> dropped_frames+1 (saturating).
  - ARMED: waits for a vsync edge -> COPY, with the copy pointer at 0. commit_req is ignored while ARMED.
  - COPY: one word per cycle with pointer p=0..NUM_WORDS-1: disp_we=1, disp_idx=p, disp_data=working[p].
    - After p=NUM_WORDS-1 -> DONE.
    - A vsync edge during COPY sets overrun. It still produces frame_tick and frame_count+1.
  - DONE: one cycle, then IDLE. If commit_req is high in DONE, go to ARMED instead.
- Latency: first disp_we occurs one cycle after the edge flag. Total copy is NUM_WORDS consecutive cycles.
- Writes:
  - wr_en in IDLE/ARMED/DONE updates working[wr_idx] at the clock edge.
  - wr_en in COPY is discarded and wr_drop_cnt+1 (saturating).
  - wr_idx >= NUM_WORDS is ignored silently.
- Same-cycle wr_en and commit_req in IDLE: the write lands, and ARMED follows. The committed data includes that write.
- disp_* outputs are registered. disp_idx/disp_data hold their last value when disp_we=0.

Optional Feature:
FRAME_COMMIT_DIRTY_EN:
- Defined: a per-word dirty bit is set on an accepted write.
- COPY still walks p=0..NUM_WORDS-1, but disp_we is asserted only for dirty words. Each dirty bit clears as its word is copied.
- Dirty bits are cleared on reset.
- Undefined: every word is copied each commit; no dirty storage is synthesised.

Decomposition:
Package frame_commit_pkg:
- state enum {IDLE, ARMED, COPY, DONE}
- IDX_W=3
- word index constants: IDX_BALL=0, IDX_LPADDLE=1, IDX_RPADDLE=2, IDX_NOTES1..IDX_NOTES4=3..6, IDX_GAME_INFO=7

Sub-module vsync_edge_sync:
- SYNC_STAGES synchroniser plus falling-edge detector
- outputs a one-cycle edge flag

Test Plan:
1. Reset, no stimulus, 3 vsync pulses -> frame_tick x3, frame_count=3, dropped_frames=3, disp_we never high.
2. Write ball=32'h1234_5678 at idx 0, pulse commit_req, vsync fall -> after SYNC_STAGES+2 cycles, disp_we high 8 cycles, idx 0..7; idx0 data 32'h12345678; busy low after DONE.
3. wr_en to idx 3 during COPY -> working[3] unchanged, wr_drop_cnt=1; next commit shows old value.
4. Second vsync edge forced during COPY -> overrun=1 (sticky), frame_count+2, copy completes all 8 words.
5. Assert reset at copy cycle 4 -> disp_we=0 immediately, state IDLE, counters 0, working cleared.
6. With FRAME_COMMIT_DIRTY_EN, write only idx 2 and 6, commit -> disp_we exactly 2 cycles, at idx 2 and 6; next commit with no writes -> zero disp_we.
